// File: rtl/vc_input_controller_pkg.sv
// Shared flit encoding, state encoding and helpers for the
// virtual-channel input controller.
package vc_input_controller_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b00;
  localparam logic [1:0] FLIT_BODY = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;
  localparam logic [1:0] FLIT_IDLE = 2'b11;

  localparam int TYPE_HI = 30;
  localparam int TYPE_LO = 29;
  localparam int DEST_HI = 28;
  localparam int DEST_LO = 27;

  localparam logic [31:0] IDLE_FLIT = 32'h6000_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROUTE  = 2'd1,
    S_ACTIVE = 2'd2
  } vc_state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] p);
    onehot4 = 4'b0001 << p;
  endfunction

endpackage

// File: rtl/vc_input_controller_fifo.sv
// Synchronous flit FIFO; DEPTH must be a power of two so the
// pointers wrap naturally at ADDR_W bits.
module vc_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [31:0]       head
);

  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_do_wr;
  logic              w_do_rd;

  // A full FIFO refuses writes even when a pop frees a slot
  assign full    = (r_count == CNT_MAX);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign head    = r_mem[r_rd_ptr];
  assign w_do_wr = wr_en & ~full;
  assign w_do_rd = rd_en & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vc_input_controller.sv
// VC input controller: buffers flits, routes head flits to one of
// four output channels. Optional counters under VC_PKT_STATS_EN.
module vc_input_controller
  import vc_input_controller_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [3:0]  gnt,
  output logic [3:0]  req,
  output logic [31:0] data_out,
  output logic        drop_err
`ifdef VC_PKT_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  drop_cnt
`endif
);

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  vc_state_t       r_state;
  logic [1:0]      r_port;
  logic [3:0]      r_req;
  logic            r_drop;

  logic            w_full;
  logic            w_empty;
  logic [ADDR_W:0] w_count;
  logic [31:0]     w_head;
  logic [1:0]      w_head_type;
  logic            w_wr;
  logic            w_grant;
  logic            w_drop;
  logic            w_act_pop;
  logic            w_pop;
  logic            w_tail_pop;

  assign in_rdy      = (w_count != CNT_MAX);
  assign w_wr        = in_val & ~w_full &
                       (data_in[TYPE_HI:TYPE_LO] != FLIT_IDLE);
  assign w_head_type = w_head[TYPE_HI:TYPE_LO];
  assign w_grant     = gnt[r_port];

  // Orphan body/tail flits at the queue head are discarded in IDLE
  assign w_drop      = (r_state == S_IDLE) & ~w_empty &
                       ((w_head_type == FLIT_BODY) |
                        (w_head_type == FLIT_TAIL));
  assign w_act_pop   = (r_state == S_ACTIVE) & w_grant & ~w_empty;
  assign w_pop       = w_drop | w_act_pop;
  assign w_tail_pop  = w_act_pop & (w_head_type == FLIT_TAIL);

  assign data_out    = w_act_pop ? w_head : IDLE_FLIT;
  assign req         = r_req;
  assign drop_err    = r_drop;

  vc_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr),
    .rd_en   (w_pop),
    .wr_data (data_in),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count),
    .head    (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_port  <= '0;
      r_req   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_drop;
      unique case (r_state)
        S_IDLE: begin
          if (~w_empty && w_head_type == FLIT_HEAD) begin
            r_port  <= w_head[DEST_HI:DEST_LO];
            r_req   <= onehot4(w_head[DEST_HI:DEST_LO]);
            r_state <= S_ROUTE;
          end
        end
        S_ROUTE: begin
          if (w_grant) r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_tail_pop) begin
            r_req   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VC_PKT_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [7:0]  r_drop_cnt;

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_tail_pop) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_input_controller.sv
// Directed scoreboard bench for vc_input_controller.
// Expected flits are queued when driven and matched on data_out.
module tb_vc_input_controller;
  import vc_input_controller_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        in_val;
  logic        in_rdy;
  logic [3:0]  gnt;
  logic [3:0]  req;
  logic [31:0] data_out;
  logic        drop_err;
`ifdef VC_PKT_STATS_EN
  logic [15:0] pkt_cnt;
  logic [7:0]  drop_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] last_out;

  vc_input_controller #(
    .DEPTH  (8),
    .ADDR_W (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .gnt      (gnt),
    .req      (req),
    .data_out (data_out),
    .drop_err (drop_err)
`ifdef VC_PKT_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t,
                                     input logic [1:0] d,
                                     input logic [15:0] p);
    mk = {1'b0, t, d, 11'd0, p};
  endfunction

  // Mid-cycle sample with scoreboard match, then step one edge
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    last_out = data_out;
    if (data_out !== IDLE_FLIT) begin
      if (sb.size() == 0) begin
        chk("sb_extra", data_out, IDLE_FLIT);
      end else begin
        e = sb.pop_front();
        chk("sb_flit", data_out, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] f, input bit exp_acc);
    data_in = f;
    in_val  = 1'b1;
    if (exp_acc) sb.push_back(f);
  endtask

  task automatic reset_dut();
    reset   = 1'b1;
    in_val  = 1'b0;
    gnt     = 4'b0000;
    data_in = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 24; i++) begin
      if (req == 4'b0000 && sb.size() == 0) break;
      cyc();
    end
    chk({tag, "_req_drop"}, req, 4'b0000);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  logic [31:0] h, b, t;

  initial begin
    reset_dut();
    chk("rst_req", req, 4'b0000);
    chk("rst_rdy", in_rdy, 1'b1);
    chk("rst_out", data_out, IDLE_FLIT);
    chk("rst_drop", drop_err, 1'b0);

    // Idle flits are never stored
    drive(IDLE_FLIT, 1'b0);
    cyc();
    cyc();
    in_val = 1'b0;
    chk("idle_cnt", dut.u_fifo.count, 0);
    chk("idle_req", req, 4'b0000);

    // Single 3-flit packet to port 2 with grant held
    gnt = 4'b0100;
    h = mk(FLIT_HEAD, 2'd2, 16'h0201);
    b = mk(FLIT_BODY, 2'd2, 16'h0202);
    t = mk(FLIT_TAIL, 2'd2, 16'h0203);
    drive(h, 1'b1);
    cyc();
    drive(b, 1'b1);
    cyc();
    chk("p1_req_c1", req, 4'b0100);
    drive(t, 1'b1);
    cyc();
    chk("p1_route_idle", last_out, IDLE_FLIT);
    in_val = 1'b0;
    cyc();
    chk("p1_c2_head", last_out, h);
    cyc();
    chk("p1_c3_body", last_out, b);
    cyc();
    chk("p1_c4_tail", last_out, t);
    chk("p1_req_c5", req, 4'b0000);
`ifdef VC_PKT_STATS_EN
    chk("p1_pkt_cnt", pkt_cnt, 16'd1);
`endif
    cyc();
    chk("p1_c5_idle", last_out, IDLE_FLIT);

    // Grant stall mid-packet
    reset_dut();
    gnt = 4'b0010;
    drive(mk(FLIT_HEAD, 2'd1, 16'h1100), 1'b1);
    cyc();
    for (int i = 1; i < 4; i++) begin
      drive(mk(FLIT_BODY, 2'd1, 16'h1100 + 16'(i)), 1'b1);
      cyc();
    end
    drive(mk(FLIT_TAIL, 2'd1, 16'h11FF), 1'b1);
    cyc();
    in_val = 1'b0;
    gnt    = 4'b0000;
    cyc();
    chk("stall_idle0", last_out, IDLE_FLIT);
    chk("stall_req0", req, 4'b0010);
    cyc();
    chk("stall_idle1", last_out, IDLE_FLIT);
    chk("stall_req1", req, 4'b0010);
    gnt = 4'b0010;
    drain("stall");

    // Full FIFO with no grant, then streaming at full
    reset_dut();
    drive(mk(FLIT_HEAD, 2'd3, 16'h3300), 1'b1);
    cyc();
    for (int i = 1; i < 8; i++) begin
      drive(mk(FLIT_BODY, 2'd3, 16'h3300 + 16'(i)), 1'b1);
      cyc();
    end
    chk("full_rdy", in_rdy, 1'b0);
    chk("full_cnt8", dut.u_fifo.count, 8);
    chk("full_req", req, 4'b1000);
    drive(mk(FLIT_BODY, 2'd3, 16'h33E9), 1'b0);
    cyc();
    chk("full_9th_drop", dut.u_fifo.count, 8);
    gnt = 4'b1000;
    drive(mk(FLIT_BODY, 2'd3, 16'h33EA), 1'b0);
    cyc();
    drive(mk(FLIT_BODY, 2'd3, 16'h33EB), 1'b0);
    cyc();
    chk("full_pop_cnt", dut.u_fifo.count, 7);
    chk("full_pop_rdy", in_rdy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(mk(FLIT_BODY, 2'd3, 16'h3340 + 16'(i)), 1'b1);
      cyc();
      chk("full_rw_cnt", dut.u_fifo.count, 7);
    end
    drive(mk(FLIT_TAIL, 2'd3, 16'h33FF), 1'b1);
    cyc();
    chk("full_rw_tail", dut.u_fifo.count, 7);
    in_val = 1'b0;
    drain("full");
    chk("full_cnt0", dut.u_fifo.count, 0);

    // Orphan body flit in IDLE
    reset_dut();
    drive(mk(FLIT_BODY, 2'd1, 16'h0B0B), 1'b0);
    cyc();
    in_val = 1'b0;
    cyc();
    chk("orph_drop1", drop_err, 1'b1);
    chk("orph_req", req, 4'b0000);
`ifdef VC_PKT_STATS_EN
    chk("orph_dcnt", drop_cnt, 8'd1);
`endif
    cyc();
    chk("orph_drop0", drop_err, 1'b0);
    chk("orph_cnt", dut.u_fifo.count, 0);
    chk("orph_req2", req, 4'b0000);

    // Asynchronous reset while ACTIVE
    reset_dut();
    gnt = 4'b0100;
    drive(mk(FLIT_HEAD, 2'd2, 16'h5500), 1'b1);
    cyc();
    drive(mk(FLIT_BODY, 2'd2, 16'h5501), 1'b1);
    cyc();
    drive(mk(FLIT_BODY, 2'd2, 16'h5502), 1'b1);
    cyc();
    in_val = 1'b0;
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req", req, 4'b0000);
    chk("arst_out", data_out, IDLE_FLIT);
    chk("arst_cnt", dut.u_fifo.count, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    gnt = 4'b0001;
    drive(mk(FLIT_HEAD, 2'd0, 16'h0A00), 1'b1);
    cyc();
    drive(mk(FLIT_TAIL, 2'd0, 16'h0A01), 1'b1);
    cyc();
    chk("arst_req0", req, 4'b0001);
    in_val = 1'b0;
    drain("arst");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
